// File: rtl/display_scan_ctrl.sv
// Four-digit common-anode 7-segment scanner with a shared hex decoder.
// Each slot opens with blanked outputs. New data is buffered and takes effect only at a frame boundary.
module display_scan_ctrl #(
    parameter int unsigned TICKS_PER_DIGIT = 6750,
    parameter int unsigned BLANK_TICKS     = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] data_i,
    input  logic        load_i,
    input  logic [3:0]  digit_en_i,
    input  logic        blank_lz_i,
    output logic [3:0]  anodo_o,
    output logic [6:0]  catodo_o,
    output logic        frame_o,
    output logic        pending_o
);

    localparam int unsigned CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    digit;
    logic [15:0]   shadow;
    logic [15:0]   pend_data;

    logic [CW-1:0] cnt_nxt;
    logic          cnt_last;
    logic          boundary;
    logic [3:0]    nibble;
    logic          lz_zero;
    logic          show;
    logic [6:0]    seg;

    // Slot sequencing, leading-zero detection and the shared decoder
    always_comb begin
        cnt_last = (cnt == CW'(TICKS_PER_DIGIT - 1));
        cnt_nxt  = cnt_last ? '0 : cnt + CW'(1);
        boundary = cnt_last && (digit == 2'd3);
        nibble   = shadow[{digit, 2'b00} +: 4];

        lz_zero = 1'b0;
        case (digit)
            2'd1:    lz_zero = (shadow[15:4]  == 12'h000);
            2'd2:    lz_zero = (shadow[15:8]  == 8'h00);
            2'd3:    lz_zero = (shadow[15:12] == 4'h0);
            default: lz_zero = 1'b0;
        endcase

        show = (state == SHOW) && digit_en_i[digit] && !(blank_lz_i && lz_zero);

        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

    // Outputs lag the scan state by one cycle so the pins see registers only
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state     <= BLANK;
            cnt       <= '0;
            digit     <= 2'd0;
            shadow    <= 16'h0000;
            pend_data <= 16'h0000;
            pending_o <= 1'b0;
            anodo_o   <= 4'b1111;
            catodo_o  <= 7'b1111111;
            frame_o   <= 1'b0;
        end else begin
            frame_o <= (digit == 2'd0) && (cnt == '0);
            if (show) begin
                anodo_o  <= ~(4'b0001 << digit);
                catodo_o <= seg;
            end else begin
                anodo_o  <= 4'b1111;
                catodo_o <= 7'b1111111;
            end

            cnt   <= cnt_nxt;
            state <= (cnt_nxt < CW'(BLANK_TICKS)) ? BLANK : SHOW;
            if (cnt_last) begin
                digit <= digit + 2'd1;
            end

            // A load landing on the boundary bypasses the pending buffer
            if (boundary) begin
                if (load_i) begin
                    shadow <= data_i;
                end else if (pending_o) begin
                    shadow <= pend_data;
                end
                pending_o <= 1'b0;
            end else if (load_i) begin
                pend_data <= data_i;
                pending_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl using 10-tick slots with 2 blank ticks.
// Each frame is checked cycle by cycle against hand-written per-slot expectations.
`timescale 1ns/100ps
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] data_i;
    logic        load_i;
    logic [3:0]  digit_en_i;
    logic        blank_lz_i;
    logic [3:0]  anodo_o;
    logic [6:0]  catodo_o;
    logic        frame_o;
    logic        pending_o;

    int checks = 0;
    int errors = 0;

    always #18.5 clk = ~clk;

    display_scan_ctrl #(
        .TICKS_PER_DIGIT(10),
        .BLANK_TICKS    (2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .load_i    (load_i),
        .digit_en_i(digit_en_i),
        .blank_lz_i(blank_lz_i),
        .anodo_o   (anodo_o),
        .catodo_o  (catodo_o),
        .frame_o   (frame_o),
        .pending_o (pending_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts on the frame_o cycle; an/cat hold per-slot expectations {slot3,slot2,slot1,slot0}.
    // la1/la2 are loop offsets at which a one-cycle load is driven (-1 for none).
    task automatic run_frame(input string name, input int n,
                             input logic [15:0] an, input logic [27:0] cat,
                             input int la1, input logic [15:0] d1,
                             input int la2, input logic [15:0] d2);
        int         slot;
        int         c;
        logic [3:0] ea;
        logic [6:0] ec;
        logic       ep;
        for (int i = 0; i < n; i++) begin
            slot = i / 10;
            c    = i % 10;
            ea   = (c < 2) ? 4'hF : an[slot*4 +: 4];
            ec   = (c < 2) ? 7'h7F : cat[slot*7 +: 7];
            ep   = (i <= 38) && ((la1 >= 0 && la1 < i && la1 != 38) ||
                                 (la2 >= 0 && la2 < i && la2 != 38));
            chk($sformatf("%s anodo i=%0d", name, i), 32'(anodo_o), 32'(ea));
            chk($sformatf("%s catodo i=%0d", name, i), 32'(catodo_o), 32'(ec));
            chk($sformatf("%s frame i=%0d", name, i), 32'(frame_o), 32'(i == 0));
            chk($sformatf("%s pending i=%0d", name, i), 32'(pending_o), 32'(ep));
            if (i == la1) begin
                load_i = 1'b1;
                data_i = d1;
            end else if (i == la2) begin
                load_i = 1'b1;
                data_i = d2;
            end else begin
                load_i = 1'b0;
            end
            tick();
        end
        load_i = 1'b0;
    endtask

    initial begin
        rst_i      = 1'b0;
        data_i     = 16'h0000;
        load_i     = 1'b0;
        digit_en_i = 4'hF;
        blank_lz_i = 1'b0;

        tick();
        tick();
        chk("reset anodo", 32'(anodo_o), 32'h0F);
        chk("reset catodo", 32'(catodo_o), 32'h7F);
        chk("reset frame", 32'(frame_o), 32'h0);
        chk("reset pending", 32'(pending_o), 32'h0);

        rst_i = 1'b1;
        tick();

        // Load 1234 lands in pending; this frame still shows 0000
        run_frame("f1", 40, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40}, 5, 16'h1234, -1, 16'h0);
        // Shows 1234; two loads, the second must win
        run_frame("f2", 40, 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 3, 16'hAAAA, 20, 16'h00F0);
        run_frame("f3", 40, 16'h7BDE, {7'h40, 7'h40, 7'h0E, 7'h40}, -1, 16'h0, -1, 16'h0);

        // Leading-zero suppression on 00F0, then a load exactly on the boundary edge
        blank_lz_i = 1'b1;
        run_frame("f4", 40, 16'hFFDE, {7'h7F, 7'h7F, 7'h0E, 7'h40}, 38, 16'h0007, -1, 16'h0);
        run_frame("f5", 40, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 5, 16'h8888, -1, 16'h0);

        // Only digits 1 and 3 enabled; stop partway into digit 2 SHOW with a load pending
        blank_lz_i = 1'b0;
        digit_en_i = 4'b1010;
        run_frame("f6", 26, 16'h7FDF, {7'h00, 7'h7F, 7'h00, 7'h7F}, 5, 16'h5555, -1, 16'h0);
        chk("pre-reset pending", 32'(pending_o), 32'h1);

        rst_i      = 1'b0;
        digit_en_i = 4'hF;
        tick();
        chk("midreset anodo", 32'(anodo_o), 32'h0F);
        chk("midreset catodo", 32'(catodo_o), 32'h7F);
        chk("midreset frame", 32'(frame_o), 32'h0);
        chk("midreset pending", 32'(pending_o), 32'h0);

        rst_i = 1'b1;
        tick();
        // Queued 5555 and the 8888 shadow are gone
        run_frame("f7", 40, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40}, -1, 16'h0, -1, 16'h0);
        chk("f8 frame period", 32'(frame_o), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
